stoch_stream_gen: RTL

Multi-channel stochastic bitstream generator: CH independent channels, each emitting a 1 with probability prob_c / 2^PW per transferred beat. Each channel has a parametrised-width maximal-length Fibonacci LFSR. Streams run for a programmed length under a start/done handshake with valid/ready backpressure. It sits between the weight/threshold registers and the stochastic arithmetic datapath.

---
 rtl/stoch_stream_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/stoch_stream_gen.sv
// Multi-channel stochastic bitstream generator: one maximal-length Fibonacci LFSR per channel,
// compared against a captured probability. Define ONES_COUNT_EN to build per-channel ones counters.
module stoch_stream_gen #(
    parameter int CH    = 4,
    parameter int W     = 16,
    parameter int PW    = 8,
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [W-1:0]          seed,
    input  logic [CH*PW-1:0]      prob,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  bits_valid,
    input  logic                  bits_ready,
    output logic [CH-1:0]         bits,
    output logic [CH*LEN_W-1:0]   ones_cnt
);

    // Tap masks hold bit (n-1) for every x^n term of the feedback polynomial.
    function automatic logic [31:0] tap_mask32(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    localparam logic [31:0]  TAP_MASK32 = tap_mask32(W);
    localparam logic [W-1:0] TAP_MASK   = TAP_MASK32[W-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               valid_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [W-1:0]       seed_reg;
    logic [CH*PW-1:0]   prob_reg;
    logic               xfer;

    assign xfer       = valid_reg & bits_ready;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign bits_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            remaining_reg <= '0;
            len_reg       <= '0;
            seed_reg      <= '0;
            prob_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        prob_reg <= prob;
                        seed_reg <= seed;
                        len_reg  <= len;
                        if (len != '0) begin
                            state_reg <= LOAD;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    remaining_reg <= len_reg;
                    state_reg     <= RUN;
                    valid_reg     <= 1'b1;
                end
                RUN: begin
                    if (xfer) begin
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1)) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
            // Abort overrides whatever the state case decided; a beat moved this cycle still
            // advances the LFSRs and counters, which are updated independently below.
            if (abort && state_reg != IDLE) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                valid_reg <= 1'b0;
                done_reg  <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [W-1:0] CH_OFS = W'(gi) << (W / 2);

            logic [W-1:0] lfsr_reg;
            logic [W-1:0] seed_mix;
            logic [W-1:0] seed_load;

            assign seed_mix  = seed_reg ^ CH_OFS;
            assign seed_load = (seed_mix == '0) ? W'(1) : seed_mix;

            always_ff @(posedge clk) begin
                if (rst) begin
                    lfsr_reg <= W'(1);
                end else if (state_reg == LOAD) begin
                    lfsr_reg <= seed_load;
                end else if (xfer) begin
                    lfsr_reg <= {lfsr_reg[W-2:0], ^(lfsr_reg & TAP_MASK)};
                end
            end

            assign bits[gi] = (lfsr_reg[PW-1:0] < prob_reg[gi*PW +: PW]);

`ifdef ONES_COUNT_EN
            logic [LEN_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst || state_reg == LOAD) begin
                    cnt_reg <= '0;
                end else if (xfer && bits[gi] && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + LEN_W'(1);
                end
            end

            assign ones_cnt[gi*LEN_W +: LEN_W] = cnt_reg;
`else
            assign ones_cnt[gi*LEN_W +: LEN_W] = '0;
`endif
        end
    endgenerate

endmodule
